// File: rtl/lu_sweep_checker_if.sv
// Bundle between the sweep checker and the OR/NOR logic unit under test.
// The checker drives the operands and select and reads back the unit's result.
interface lu_sweep_checker_if;
  logic lu_a;
  logic lu_b;
  logic lu_select;
  logic lu_result;

  modport master (output lu_a, lu_b, lu_select, input lu_result);
  modport slave  (input lu_a, lu_b, lu_select, output lu_result);
endinterface

// File: rtl/lu_sweep_checker.sv
// Steps the logic unit through all 8 {select,a,b} combinations and checks each
// result against OR/NOR. It reports the observed table, the error count and the first failing index.
//
// state  | meaning
// IDLE   | waiting for start; results held, operands driven low
// SETTLE | vector idx applied; counting down wait_cnt, sampling when it hits 0
module lu_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  lu_sweep_checker_if.master  lu,
  output logic                busy,
  output logic                done,
  output logic [7:0]          obs_table,
  output logic [3:0]          err_count,
  output logic [2:0]          first_fail,
  output logic                fail_valid,
  output logic                pass
);

  typedef enum logic {IDLE, SETTLE} state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  state_t     state, state_nxt;
  logic [2:0] idx, idx_nxt;
  logic [3:0] wait_cnt, wait_nxt;
  logic       done_nxt, fv_nxt, pass_nxt;
  logic [7:0] tbl_nxt;
  logic [3:0] err_nxt;
  logic [2:0] ff_nxt;
  logic       exp_bit, mismatch;

  assign exp_bit  = idx[2] ? (idx[1] | idx[0]) : ~(idx[1] | idx[0]);
  assign mismatch = lu.lu_result != exp_bit;

  assign busy         = (state == SETTLE);
  assign lu.lu_select = busy & idx[2];
  assign lu.lu_a      = busy & idx[1];
  assign lu.lu_b      = busy & idx[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 3'd0;
      wait_cnt   <= 4'd0;
      done       <= 1'b0;
      obs_table  <= 8'd0;
      err_count  <= 4'd0;
      first_fail <= 3'd0;
      fail_valid <= 1'b0;
      pass       <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      wait_cnt   <= wait_nxt;
      done       <= done_nxt;
      obs_table  <= tbl_nxt;
      err_count  <= err_nxt;
      first_fail <= ff_nxt;
      fail_valid <= fv_nxt;
      pass       <= pass_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wait_nxt  = wait_cnt;
    done_nxt  = 1'b0;
    tbl_nxt   = obs_table;
    err_nxt   = err_count;
    ff_nxt    = first_fail;
    fv_nxt    = fail_valid;
    pass_nxt  = pass;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETTLE;
          idx_nxt   = 3'd0;
          wait_nxt  = SETTLE_LD;
          tbl_nxt   = 8'd0;
          err_nxt   = 4'd0;
          ff_nxt    = 3'd0;
          fv_nxt    = 1'b0;
          pass_nxt  = 1'b0;
        end
      end
      SETTLE: begin
        if (wait_cnt != 4'd0) begin
          wait_nxt = wait_cnt - 4'd1;
        end else begin
          tbl_nxt[idx] = lu.lu_result;
          if (mismatch) begin
            err_nxt = err_count + 4'd1;
            if (!fail_valid) begin
              ff_nxt = idx;
              fv_nxt = 1'b1;
            end
          end
          if (idx != 3'd7) begin
            idx_nxt  = idx + 3'd1;
            wait_nxt = SETTLE_LD;
          end else begin
            // pass must see the mismatch from this final sample as well
            state_nxt = IDLE;
            done_nxt  = 1'b1;
            pass_nxt  = (err_nxt == 4'd0);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lu_sweep_checker.sv
// Directed bench for lu_sweep_checker: a behavioural logic unit with selectable
// faults, two checker instances (SETTLE_CYCLES=2 and 0).
module tb_lu_sweep_checker;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [7:0] tbl;
    logic [3:0] err;
    logic [2:0] ff;
    logic       fv;
    logic       pass;
  } outs_t;

  typedef struct {
    int         d;
    int         mode;
    logic [7:0] tbl;
    int         err;
    int         ff;
    int         fv;
    int         pass;
  } vec_t;

  logic clk = 1'b0;
  logic reset0 = 1'b1, reset1 = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  int   mode = 0;
  int   errors = 0;
  int   checks = 0;

  outs_t o0, o1;

  lu_sweep_checker_if lu0 ();
  lu_sweep_checker_if lu1 ();

  always #5 clk = ~clk;

  // mode: 0 golden, 1 stuck at 0, 2 select inverted, 3 idx 6 forced 0, 4 stuck at 1
  function automatic logic unit_model(input logic s, input logic a, input logic b, input int m);
    logic o;
    o = s ? (a | b) : ~(a | b);
    case (m)
      1: o = 1'b0;
      2: o = ~s ? (a | b) : ~(a | b);
      3: if ({s, a, b} == 3'd6) o = 1'b0;
      4: o = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  assign lu0.lu_result = unit_model(lu0.lu_select, lu0.lu_a, lu0.lu_b, mode);
  assign lu1.lu_result = unit_model(lu1.lu_select, lu1.lu_a, lu1.lu_b, mode);

  lu_sweep_checker #(.SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .reset(reset0), .start(start0), .lu(lu0.master),
    .busy(o0.busy), .done(o0.done), .obs_table(o0.tbl), .err_count(o0.err),
    .first_fail(o0.ff), .fail_valid(o0.fv), .pass(o0.pass)
  );

  lu_sweep_checker #(.SETTLE_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset1), .start(start1), .lu(lu1.master),
    .busy(o1.busy), .done(o1.done), .obs_table(o1.tbl), .err_count(o1.err),
    .first_fail(o1.ff), .fail_valid(o1.fv), .pass(o1.pass)
  );

  function automatic outs_t get(input int d);
    return (d == 0) ? o0 : o1;
  endfunction

  function automatic logic [2:0] get_lu(input int d);
    return (d == 0) ? {lu0.lu_select, lu0.lu_a, lu0.lu_b} : {lu1.lu_select, lu1.lu_a, lu1.lu_b};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic set_start(input int d, input logic v);
    if (d == 0) start0 = v; else start1 = v;
  endtask

  task automatic set_reset(input int d, input logic v);
    if (d == 0) reset0 = v; else reset1 = v;
  endtask

  task automatic chk_all_zero(input string name, input int d);
    chk({name, "_outs"}, int'(get(d)), 0);
    chk({name, "_lu"}, int'(get_lu(d)), 0);
  endtask

  // One-cycle start pulse; count busy and done cycles until a few cycles past done.
  task automatic sweep(input int d, output int nbusy, output int ndone);
    outs_t ob;
    int    tail;
    bit    seen;
    nbusy = 0; ndone = 0; tail = 0; seen = 0;
    @(negedge clk); set_start(d, 1'b1);
    @(negedge clk); set_start(d, 1'b0);
    for (int g = 0; g < 300; g++) begin
      ob = get(d);
      nbusy += int'(ob.busy);
      ndone += int'(ob.done);
      if (ob.done) seen = 1;
      if (seen) tail++;
      if (tail > 3) break;
      @(negedge clk);
    end
    if (!seen) chk("sweep_timeout", 0, 1);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int    nb, nd, exp_busy;
    outs_t ob;
    mode = v.mode;
    exp_busy = (v.d == 0) ? 24 : 8;
    sweep(v.d, nb, nd);
    ob = get(v.d);
    chk({name, "_busy_cycles"}, nb, exp_busy);
    chk({name, "_done_pulses"}, nd, 1);
    chk({name, "_table"}, int'(ob.tbl), int'(v.tbl));
    chk({name, "_err_count"}, int'(ob.err), v.err);
    chk({name, "_first_fail"}, int'(ob.ff), v.ff);
    chk({name, "_fail_valid"}, int'(ob.fv), v.fv);
    chk({name, "_pass"}, int'(ob.pass), v.pass);
  endtask

  task automatic reset_mid(input string name, input int d, input int at_cycle);
    int nd;
    mode = 0;
    @(negedge clk); set_start(d, 1'b1);
    @(negedge clk); set_start(d, 1'b0);
    for (int i = 1; i < at_cycle; i++) @(negedge clk);
    chk({name, "_busy_before"}, int'(get(d).busy), 1);
    set_reset(d, 1'b1);
    @(negedge clk); set_reset(d, 1'b0);
    chk_all_zero(name, d);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      nd += int'(get(d).done);
    end
    chk({name, "_no_done"}, nd, 0);
  endtask

  vec_t vecs[7];

  initial begin
    outs_t ob;
    int    nb;
    bit    seen;

    vecs[0] = '{d: 0, mode: 0, tbl: 8'hE1, err: 0, ff: 0, fv: 0, pass: 1};
    vecs[1] = '{d: 0, mode: 1, tbl: 8'h00, err: 4, ff: 0, fv: 1, pass: 0};
    vecs[2] = '{d: 0, mode: 2, tbl: 8'h1E, err: 8, ff: 0, fv: 1, pass: 0};
    vecs[3] = '{d: 0, mode: 3, tbl: 8'hA1, err: 1, ff: 6, fv: 1, pass: 0};
    vecs[4] = '{d: 0, mode: 4, tbl: 8'hFF, err: 4, ff: 1, fv: 1, pass: 0};
    vecs[5] = '{d: 1, mode: 0, tbl: 8'hE1, err: 0, ff: 0, fv: 0, pass: 1};
    vecs[6] = '{d: 1, mode: 3, tbl: 8'hA1, err: 1, ff: 6, fv: 1, pass: 0};

    repeat (3) @(negedge clk);
    reset0 = 1'b0; reset1 = 1'b0;
    @(negedge clk);
    chk_all_zero("reset_d0", 0);
    chk_all_zero("reset_d1", 1);

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // start held high: one sweep, then an immediate restart from the done cycle
    mode = 0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk);
    nb = 0; seen = 0;
    for (int g = 0; g < 100; g++) begin
      ob = get(0);
      if (ob.done) begin seen = 1; break; end
      nb += int'(ob.busy);
      @(negedge clk);
    end
    chk("held_done_seen", int'(seen), 1);
    chk("held_busy_cycles", nb, 24);
    chk("held_done_table", int'(get(0).tbl), 8'hE1);
    @(negedge clk);
    ob = get(0);
    chk("held_restart_table", int'(ob.tbl), 0);
    chk("held_restart_busy", int'(ob.busy), 1);
    chk("held_restart_done", int'(ob.done), 0);
    start0 = 1'b0;
    seen = 0;
    for (int g = 0; g < 100; g++) begin
      @(negedge clk);
      if (get(0).done) begin seen = 1; break; end
    end
    chk("held_second_done", int'(seen), 1);
    chk("held_second_table", int'(get(0).tbl), 8'hE1);
    chk("held_second_pass", int'(get(0).pass), 1);

    // load a failing result first so the reset clear is visible
    run_vec("pre_rst_d0", vecs[3]);
    reset_mid("rst_d0", 0, 10);
    run_vec("post_rst_d0", vecs[0]);
    run_vec("pre_rst_d1", vecs[6]);
    reset_mid("rst_d1", 1, 5);
    run_vec("post_rst_d1", vecs[5]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lu_sweep_checker.md
Name: lu_sweep_checker

Overview:
- Sequential driver and checker for the two-input OR/NOR selectable logic unit. It sits on the other side of the unit's a/b/select/result interface.
- On a start pulse it steps through all 8 operand/select combinations and drives each one onto the unit. After a settle interval it samples the unit's result.
- It builds the observed truth table and compares each entry against the expected OR/NOR function. It reports the error count, the first failing index and pass/fail with a done pulse.

Parameters:
SETTLE_CYCLES, 2, extra cycles each vector is held before sampling (0 allowed; legal range 0..15)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
start  input  1  request a sweep; sampled only in IDLE
lu_a  output  1  operand a driven to the logic unit
lu_b  output  1  operand b driven to the logic unit
lu_select  output  1  select driven to the logic unit (0 = NOR, 1 = OR)
lu_result  input  1  logic-unit output under test
busy  output  1  high while a sweep is in progress
done  output  1  one-cycle pulse when the sweep completes
table  output  8  observed result; bit i = result for index i
err_count  output  4  number of mismatching indices (0..8)
first_fail  output  3  lowest mismatching index
fail_valid  output  1  at least one mismatch; first_fail is meaningful
pass  output  1  last completed sweep had zero mismatches

Behaviour:
- Index encoding: idx[2:0] = {select, a, b}. Operand outputs are decoded directly from the registered idx while busy; all three are 0 in IDLE.
- Expected function: exp = select ? (a|b) : ~(a|b). The golden table is 8'hE1.
- Reset values: state IDLE, idx 0, wait counter 0, and all outputs 0 (lu_*, busy, done, table, err_count, first_fail, fail_valid, pass).
- States: IDLE, SETTLE.
- IDLE, start=1 at an edge: go to SETTLE with idx=0 and wait=SETTLE_CYCLES. In the same edge clear table, err_count, first_fail, fail_valid and pass.
- SETTLE, wait!=0: wait decrements and idx is held.
- SETTLE, wait==0 (sample edge):
  - table[idx] <= lu_result.
  - If lu_result != exp(idx): err_count increments; if fail_valid is still 0, first_fail <= idx and fail_valid <= 1.
  - If idx!=7: idx increments and wait reloads SETTLE_CYCLES.
  - If idx==7: go to IDLE, done <= 1 for one cycle, pass <= (final err_count==0).
- Timing:
  - Each vector is held SETTLE_CYCLES+1 cycles.
  - busy is high for exactly 8*(SETTLE_CYCLES+1) cycles, starting the cycle after start is accepted.
  - done is high in the first cycle busy is low.
- The error count includes the mismatch found on the last sample edge. err_count never exceeds 8, so there is no saturation.
- start while busy is ignored, with no restart and no queuing.
- start high in the done cycle (state already IDLE) is accepted: a new sweep begins, results clear, and done drops next cycle.
- Results (table, err_count, first_fail, fail_valid, pass) hold stable in IDLE until the next accepted start.
- reset has priority over everything. Asserted mid-sweep, it forces all reset values at that edge, and no done is produced for the aborted sweep.
- lu_result is treated as combinational from the lu_* outputs. It is sampled only on sample edges; it is ignored in IDLE and on non-sample SETTLE cycles.

Test Plan:
- Golden OR/NOR unit connected, SETTLE_CYCLES=2, 1-cycle start pulse -> busy high 24 cycles, done pulse once, table=8'hE1, err_count=0, fail_valid=0, pass=1.
- Unit output stuck at 0 -> table=8'h00, err_count=4 (idx 0,5,6,7), first_fail=0, fail_valid=1, pass=0.
- Unit with select inverted (OR on select=0) -> table=8'h1E, err_count=8, first_fail=0, pass=0.
- Unit correct except idx 6 forced to 0 -> table=8'hA1, err_count=1, first_fail=6, pass=0.
- start held high through the whole sweep -> single sweep runs and start is ignored while busy. Because start is still high in the done cycle, a second sweep starts immediately: table clears to 8'h00 next cycle and busy reasserts.
- reset pulsed at cycle 10 of a sweep -> next cycle all outputs 0, no done. A following start gives a normal full result. Repeat with SETTLE_CYCLES=0: busy lasts 8 cycles, table=8'hE1.
